// File: rtl/fp16_pair_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pack_pkg
// Description : Shared constants, flag-bit indices and the pair-packer state
//               type for the fp16 pair packer.
//               Used by fp16_pair_packer and fp16_nan_canon.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pack_pkg;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    // Bit positions inside the {invalid, underflow, overflow} flag vector
    localparam int FLG_NV = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 0;

    // EMPTY: no half held; HALF: low half waiting in the holding register
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // NaN: all-ones exponent with a non-zero mantissa
    function automatic logic fp16_is_nan(input logic [15:0] value);
        return (value[14:10] == FP16_EXP_MAX) && (value[9:0] != 10'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_pair_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pair_packer_if
// Description : Element-in / packed-word-out handshake bundle of the packer.
//   Input stream  : in_valid, in_ready, in_fp16, in_invalid, in_underflow,
//                   in_overflow, in_last
//   Output stream : out_valid, out_ready, out_data[31:0], out_mask[1:0],
//                   out_last
//   master : drives elements and out_ready (producer/consumer side)
//   slave  : the packer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_pair_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_fp16;
    logic        in_invalid;
    logic        in_underflow;
    logic        in_overflow;
    logic        in_last;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mask;
    logic        out_last;

    modport master (
        output in_valid, in_fp16, in_invalid, in_underflow, in_overflow,
               in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_last
    );

    modport slave (
        input  in_valid, in_fp16, in_invalid, in_underflow, in_overflow,
               in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_last
    );

endinterface
`default_nettype wire

// File: rtl/fp16_pair_packer_nan_canon.sv
`default_nettype none
// ============================================================================
// Module      : fp16_nan_canon
// Description : Combinational NaN canonicaliser. Any element flagged invalid,
//               or carrying a NaN encoding, becomes the positive quiet NaN.
//               Only built when FP16_PACK_NAN_CANON_EN is defined.
//   fp16_in  [15:0] in  : raw element
//   invalid         in  : converter invalid flag for the element
//   fp16_out [15:0] out : element after canonicalisation
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_nan_canon
    import fp16_pack_pkg::*;
(
    input  logic [15:0] fp16_in,
    input  logic        invalid,
    output logic [15:0] fp16_out
);

    assign fp16_out = (invalid || fp16_is_nan(fp16_in)) ? FP16_QNAN : fp16_in;

endmodule
`default_nettype wire

// File: rtl/fp16_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pair_packer
// Description : Packs consecutive fp16 elements into 32-bit words (first
//               element in the low half), pads odd vector tails with PAD and
//               accumulates sticky {invalid, underflow, overflow} flags.
//   clk, rst (async, active-high)
//   bus          : fp16_pair_packer_if.slave (element in, packed word out)
//   flags_clr    in  : clear sticky flags (a same-cycle new flag survives)
//   sticky_flags out : {invalid, underflow, overflow}
//   word_count   out : words emitted since reset, wraps
// Build option : FP16_PACK_NAN_CANON_EN - replace invalid/NaN elements by
//                the canonical quiet NaN before packing.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_pair_packer
    import fp16_pack_pkg::*;
#(
    parameter logic [15:0] PAD   = 16'h0000,
    parameter int          CNT_W = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    fp16_pair_packer_if.slave    bus,
    input  logic                 flags_clr,
    output logic [2:0]           sticky_flags,
    output logic [CNT_W-1:0]     word_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    pack_state_t      r_state;
    logic [15:0]      r_hold_lo;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [1:0]       r_out_mask;
    logic             r_out_last;
    logic [2:0]       r_flags;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [15:0]      w_elem;
    logic [2:0]       w_new_flags;

    // A new element may enter whenever the output slot is free or is being
    // drained this cycle; a load then replaces the draining word directly.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

`ifdef FP16_PACK_NAN_CANON_EN
    fp16_nan_canon u_nan_canon (
        .fp16_in  (bus.in_fp16),
        .invalid  (bus.in_invalid),
        .fp16_out (w_elem)
    );
`else
    assign w_elem = bus.in_fp16;
`endif

    always_comb begin
        w_new_flags         = 3'b000;
        w_new_flags[FLG_NV] = bus.in_invalid;
        w_new_flags[FLG_UF] = bus.in_underflow;
        w_new_flags[FLG_OF] = bus.in_overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_hold_lo   <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_out_mask  <= 2'b00;
            r_out_last  <= 1'b0;
            r_flags     <= 3'b000;
            r_count     <= '0;
        end else begin
            // Drain first; a load below overrides this in the same cycle.
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_fire) begin
                case (r_state)
                    EMPTY: begin
                        if (bus.in_last) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= {PAD, w_elem};
                            r_out_mask  <= 2'b01;
                            r_out_last  <= 1'b1;
                        end else begin
                            r_hold_lo <= w_elem;
                            r_state   <= HALF;
                        end
                    end
                    HALF: begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {w_elem, r_hold_lo};
                        r_out_mask  <= 2'b11;
                        r_out_last  <= bus.in_last;
                        r_state     <= EMPTY;
                    end
                    default: r_state <= EMPTY;
                endcase
            end

            r_flags <= (flags_clr ? 3'b000 : r_flags)
                     | (w_in_fire ? w_new_flags : 3'b000);

            if (w_out_fire) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_last  = r_out_last;
    assign sticky_flags  = r_flags;
    assign word_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fp16_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_pair_packer
// Description : Self-checking bench for fp16_pair_packer. Directed steps
//               followed by a randomized phase; expected words come from a
//               vector-level model (each finished vector is cut into pairs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flags_clr;
    logic [2:0]  sticky_flags;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fp16_pair_packer_if bus ();

    fp16_pair_packer #(.PAD(16'h0000), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags),
        .word_count   (word_count)
    );

    int total = 0;
    int bad   = 0;

    // Model state: {last, mask, data} words
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    logic [15:0] vec[$];
    logic [2:0]  m_flags;
    int          m_words;
    bit          rnd_mode;
    logic        rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model_elem(input logic [15:0] e, input logic inv);
`ifdef FP16_PACK_NAN_CANON_EN
        if (inv || (e[14:10] == 5'h1F && e[9:0] != 10'd0)) return 16'h7E00;
`endif
        return e;
    endfunction

    // A finished vector is emitted as pairs, low element first; an odd tail
    // is padded with zero in the high half.
    task automatic close_vector();
        for (int i = 0; i < vec.size(); i += 2) begin
            if (i + 1 < vec.size())
                exp_q.push_back({(i + 2 >= vec.size()), 2'b11, vec[i+1], vec[i]});
            else
                exp_q.push_back({1'b1, 2'b01, 16'h0000, vec[i]});
            m_words++;
        end
        vec.delete();
    endtask

    // Output monitor: samples just before each rising edge
    initial forever begin
        @(negedge clk);
        #4;
        if (!rst && bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_last, bus.out_mask, bus.out_data});
    end

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input logic [15:0] e, input logic inv, input logic uf,
                        input logic of, input logic last, input logic clr,
                        output logic rdy_first);
        bit done = 0;
        rdy_first = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_fp16      = e;
        bus.in_invalid   = inv;
        bus.in_underflow = uf;
        bus.in_overflow  = of;
        bus.in_last      = last;
        flags_clr        = clr;
        for (int k = 0; k < 200 && !done; k++) begin
            if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (k == 0) rdy_first = bus.in_ready;
            if (clr) m_flags = 3'b000;
            if (bus.in_ready) begin
                done = 1;
                m_flags = m_flags | {inv, uf, of};
                vec.push_back(model_elem(e, inv));
                if (last) close_vector();
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        flags_clr    = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && bus.out_valid; k++) @(negedge clk);
        chk({tag, "_drained"}, bus.out_valid, 0);
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_count"}, word_count, m_words[15:0]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flags_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_fp16 = 16'h0;
        bus.in_invalid = 1'b0;
        bus.in_underflow = 1'b0;
        bus.in_overflow = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        rnd_mode = 0;
        m_flags = 3'b000;
        m_words = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_mask", bus.out_mask, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_flags", sticky_flags, 0);
        chk("rst_count", word_count, 0);
        rst = 1'b0;

        // Pair pack with out_ready held high
        send(16'h3C00, 0, 0, 0, 0, 0, rdy);
        chk("t1_in_ready0", rdy, 1);
        send(16'hBC00, 0, 0, 0, 1, 0, rdy);
        chk("t1_in_ready1", rdy, 1);
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 32'hBC003C00);
        chk("t1_out_mask", bus.out_mask, 2'b11);
        chk("t1_out_last", bus.out_last, 1);
        chk("t1_in_ready2", bus.in_ready, 1);
        idle(1);
        chk("t1_count", word_count, 1);
        drain("t1");

        // Odd-length vector
        send(16'h4248, 0, 0, 0, 0, 0, rdy);
        send(16'h4900, 0, 0, 0, 0, 0, rdy);
        send(16'hC900, 0, 0, 0, 1, 0, rdy);
        chk("t2_first_word", (got_q.size() > 0) ? got_q[0] : 35'h0, {1'b0, 2'b11, 32'h49004248});
        chk("t2_tail_data", bus.out_data, 32'h0000C900);
        chk("t2_tail_mask", bus.out_mask, 2'b01);
        chk("t2_tail_last", bus.out_last, 1);
        drain("t2");

        // Backpressure, then drain and reload in the same cycle
        bus.out_ready = 1'b0;
        send(16'h3800, 0, 0, 0, 0, 0, rdy);
        send(16'h3A00, 0, 0, 0, 1, 0, rdy);
        for (int c = 0; c < 5; c++) begin
            chk("t3_in_ready", bus.in_ready, 0);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_data", bus.out_data, 32'h3A003800);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(16'h3555, 0, 0, 0, 1, 0, rdy);
        chk("t3_reload_rdy", rdy, 1);
        chk("t3_reload_valid", bus.out_valid, 1);
        chk("t3_reload_data", bus.out_data, 32'h00003555);
        chk("t3_reload_mask", bus.out_mask, 2'b01);
        drain("t3");

        // Sticky flags
        send(16'h7C00, 0, 0, 1, 1, 0, rdy);
        chk("t4_of", sticky_flags, 3'b001);
        idle(2);
        chk("t4_of_hold", sticky_flags, 3'b001);
        send(16'h0001, 0, 1, 0, 1, 0, rdy);
        chk("t4_uf", sticky_flags, 3'b011);
        send(16'h7FFF, 1, 0, 0, 1, 1, rdy);
        chk("t4_clr_nv", sticky_flags, 3'b100);
        chk("t4_model", sticky_flags, m_flags);
        drain("t4");

        // Asynchronous reset with a half held
        send(16'h3C01, 0, 0, 0, 0, 0, rdy);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_data", bus.out_data, 0);
        chk("t5_rst_mask", bus.out_mask, 0);
        chk("t5_rst_last", bus.out_last, 0);
        chk("t5_rst_flags", sticky_flags, 0);
        chk("t5_rst_count", word_count, 0);
        vec.delete();
        exp_q.delete();
        got_q.delete();
        m_flags = 3'b000;
        m_words = 0;
        @(negedge clk);
        rst = 1'b0;
        send(16'h0400, 0, 0, 0, 0, 0, rdy);
        send(16'h0001, 0, 0, 0, 1, 0, rdy);
        chk("t5_data", bus.out_data, 32'h00010400);
        chk("t5_mask", bus.out_mask, 2'b11);
        chk("t5_last", bus.out_last, 1);
        drain("t5");

        // NaN handling
        send(16'h7FFF, 1, 0, 0, 0, 0, rdy);
        send(16'hFFFF, 0, 0, 0, 1, 0, rdy);
`ifdef FP16_PACK_NAN_CANON_EN
        chk("t6_nan_data", bus.out_data, 32'h7E007E00);
`else
        chk("t6_nan_data", bus.out_data, 32'hFFFF7FFF);
`endif
        drain("t6");

        // Randomized vectors with random backpressure and gaps
        rnd_mode = 1;
        for (int v = 0; v < 80; v++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                logic [15:0] e;
                if ($urandom_range(0, 7) == 0)
                    e = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
                else
                    e = 16'($urandom);
                send(e, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) == 0), (j == len - 1),
                     ($urandom_range(0, 11) == 0), rdy);
                chk("rnd_flags", sticky_flags, m_flags);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rnd_mode = 0;
        drain("rnd");
        chk("rnd_final_flags", sticky_flags, m_flags);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_pair_packer.md
Name: fp16_pair_packer

Overview:
- Downstream stage of the fp32-to-fp16 converter in the tensor core.
- Consumes a stream of fp16 results, each with its invalid/underflow/overflow flags, over a valid/ready handshake.
- Packs consecutive pairs into 32-bit words (first element in the low half) for the register-file/memory write path.
- Accumulates sticky exception flags for the fflags-style status register.

Parameters:
PAD, 16'h0000, fill value for the unused high half when a vector ends on an odd element.
CNT_W, 16, width of the emitted-word counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input element valid
in_ready  out  1  stage can accept an element
in_fp16  in  16  fp16 element
in_invalid  in  1  converter invalid flag for this element
in_underflow  in  1  converter underflow flag for this element
in_overflow  in  1  converter overflow flag for this element
in_last  in  1  element is the last of its vector
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts the word
out_data  out  32  {hi, lo} packed fp16 pair
out_mask  out  2  half valid bits; bit0 = lo, bit1 = hi
out_last  out  1  word closes a vector
flags_clr  in  1  clear sticky flags
sticky_flags  out  3  {invalid, underflow, overflow}, sticky
word_count  out  CNT_W  words emitted since reset, wraps

Behaviour:
- Single clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_mask=0, out_last=0, sticky_flags=0, word_count=0, state=EMPTY, low-half holding register=0.
- Transfer definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- in_ready = !out_valid | out_ready. It is combinational from out_ready, and the rule applies in both states.
- States: EMPTY (no half held) and HALF (low half held in hold_lo).
- EMPTY, in_fire, !in_last: hold_lo <= in_fp16; go to HALF; no output.
- EMPTY, in_fire, in_last: load output with out_data={PAD,in_fp16}, out_mask=2'b01, out_last=1; stay EMPTY.
- HALF, in_fire: load output with out_data={in_fp16,hold_lo}, out_mask=2'b11, out_last=in_last; go to EMPTY.
- Output register:
  - Loading sets out_valid=1 next cycle.
  - out_fire with no load in the same cycle clears out_valid.
  - out_fire with a load in the same cycle replaces the word; there is no bubble.
  - out_data, out_mask and out_last are held stable while out_valid & !out_ready.
- Latency: one cycle from the completing in_fire to out_valid. Full throughput is one element per cycle, i.e. one word per two cycles.
- Sticky flags: next = (flags_clr ? 0 : cur) | (in_fire ? {in_invalid,in_underflow,in_overflow} : 0). A clear and a new flag in the same cycle leaves the new flag set.
- word_count increments by 1 on each out_fire and wraps from all-ones to 0.
- When in_valid is low, state and hold_lo are held.
- A held half in HALF waits indefinitely for the next element; there is no timeout.
- Reset mid-vector: the held half and any pending output word are discarded; flags and count are zeroed.

Optional Feature:
- Macro FP16_PACK_NAN_CANON_EN.
- When defined: any accepted element with in_invalid=1, or with a NaN encoding (exp=5'h1F, mant!=0), is replaced by the canonical quiet NaN 16'h7E00 (sign dropped) before packing. Flags are unaffected.
- When undefined: elements are packed bit-exact, so 16'h7FFF passes through unchanged.

Decomposition:
- Package fp16_pack_pkg holds:
  - FP16_QNAN = 16'h7E00
  - FP16_EXP_MAX = 5'h1F
  - flag-bit index constants FLG_NV=2, FLG_UF=1, FLG_OF=0
  - the two-state enum (EMPTY, HALF)
- Sub-module fp16_nan_canon (combinational, 16-bit in/out plus invalid in) is instantiated only under FP16_PACK_NAN_CANON_EN.

Test Plan:
- Pair pack with out_ready=1: send 3C00 then BC00 (last) → one word 32'hBC003C00, mask 11, last=1, word_count=1, in_ready constantly 1.
- Odd vector: send 4248, 4900, C900 (last) → words 32'h49004248 (mask 11, last 0) then 32'h0000C900 (mask 01, last 1).
- Backpressure: hold out_ready=0 with a word pending → in_ready=0, out_data stable for 5 cycles. Then raise out_ready while a completing pair is presented the same cycle → new word loaded back-to-back, no loss or duplication.
- Sticky flags:
  - element with overflow=1 (7C00) → sticky_flags=001 persists.
  - element with underflow=1 → 011.
  - flags_clr together with an in_fire carrying invalid=1 → 100.
- Reset mid-vector: accept 3C01 (HALF), assert rst asynchronously between edges → outputs zero immediately. Then send 0400, 0001 (last) → word 32'h00010400.
- Macro on: send 7FFF (invalid=1) and FFFF (invalid=0), last on the second → word 32'h7E007E00. Macro off → 32'hFFFF7FFF.
